quad_step_gen: RTL and testbench



---
 rtl/quad_step_gen_if.sv | 25 ++
 rtl/quad_step_gen.sv | 127 ++++++++++++
 tb/tb_quad_step_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/quad_step_gen_if.sv
// Command channel of the quadrature step generator: a signed step count and an
// edge period, transferred with a valid/ready handshake.
interface quad_step_gen_if #(
    parameter int WIDTH = 22,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/quad_step_gen.sv
// Quadrature step generator: turns signed step commands into a glitch-free A/B
// Gray sequence at a programmable edge rate and tracks the decoded position.
module quad_step_gen #(
    parameter int WIDTH = 22,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    quad_step_gen_if.slave   cmd,
    input  logic             abort,
    output logic             quadA,
    output logic             quadB,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] per_q, per_d;

    logic             accept;
    logic [WIDTH-1:0] step_mag;
    logic [DIV_W-1:0] per_in;

    assign cmd.cmd_ready = (state_q == IDLE) & ~abort;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    // Unsigned magnitude: the most negative command maps onto 2^(WIDTH-1).
    assign step_mag      = cmd.cmd_steps[WIDTH-1] ? -cmd.cmd_steps : cmd.cmd_steps;
    assign per_in        = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pos_d   = pos_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dir_d   = dir_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        per_d   = per_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = cmd.cmd_steps[WIDTH-1];
                        rem_d   = step_mag;
                        per_d   = per_in;
                        timer_d = per_in - DIV_W'(1);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort outranks a coincident edge; phase and position hold.
                    rem_d   = '0;
                    timer_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    // Forward 00->10->11->01 is A'=~B, B'=A; reverse is the inverse.
                    a_d     = dir_q ? b_q : ~b_q;
                    b_d     = dir_q ? ~a_q : a_q;
                    pos_d   = pos_q + (dir_q ? {WIDTH{1'b1}} : WIDTH'(1));
                    rem_d   = rem_q - WIDTH'(1);
                    timer_d = per_q - DIV_W'(1);
                    if (rem_q == WIDTH'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            timer_q <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            per_q   <= per_d;
        end
    end

    assign quadA    = a_q;
    assign quadB    = b_q;
    assign position = pos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: directed and random commands compared
// against an edge-count model of phase, position, busy and done.
module tb_quad_step_gen;

    localparam int WIDTH = 22;
    localparam int DIV_W = 16;
    localparam logic [31:0] POS_MASK = 32'h003F_FFFF;

    logic             clk;
    logic             nrst;
    logic             abort;
    logic             quadA;
    logic             quadB;
    logic [WIDTH-1:0] position;
    logic             busy;
    logic             done;

    int errors;
    int checks;

    // Model state: decoded position and Gray index (0:00, 1:10, 2:11, 3:01).
    int model_pos;
    int model_idx;

    quad_step_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) cmd_if ();

    quad_step_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .cmd      (cmd_if),
        .abort    (abort),
        .quadA    (quadA),
        .quadB    (quadB),
        .position (position),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs after `edges` edges of direction `dir` from the model state.
    task automatic checkModel(input string tag, input int dir, input int edges,
                              input logic busy_exp, input logic done_exp);
        int idx;
        logic [31:0] pos_exp;
        idx     = (((model_idx + dir * edges) % 4) + 4) % 4;
        pos_exp = 32'(model_pos + dir * edges) & POS_MASK;
        checkOutput({tag, "_A"}, 32'(quadA), 32'((idx == 1) || (idx == 2)));
        checkOutput({tag, "_B"}, 32'(quadB), 32'(idx >= 2));
        checkOutput({tag, "_pos"}, 32'(position), pos_exp);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(busy_exp));
        checkOutput({tag, "_done"}, 32'(done), 32'(done_exp));
    endtask

    task automatic commitModel(input int dir, input int edges);
        model_pos = (model_pos + dir * edges) & 32'h003F_FFFF;
        model_idx = (((model_idx + dir * edges) % 4) + 4) % 4;
    endtask

    // Issue one command; abort_at>0 raises abort so the edge abort_at cycles
    // after acceptance sees it. Outputs are checked every cycle.
    task automatic applyStimulus(input string tag, input int steps, input int period,
                                 input int abort_at);
        int n, p, dir, total, last_k, edges;
        n   = (steps < 0) ? -steps : steps;
        p   = (period == 0) ? 1 : period;
        dir = (steps < 0) ? -1 : 1;
        total = n * p;

        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = steps[WIDTH-1:0];
        cmd_if.cmd_period = period[DIV_W-1:0];
        #0;
        checkOutput({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
        stepClk();
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_steps  = WIDTH'($urandom);
        cmd_if.cmd_period = DIV_W'($urandom);

        if (n == 0) begin
            checkModel({tag, "_zero"}, 1, 0, 1'b0, 1'b1);
            stepClk();
            checkModel({tag, "_zero_after"}, 1, 0, 1'b0, 1'b0);
            return;
        end

        last_k = (abort_at > 0) ? abort_at - 1 : total;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) stepClk();
            checkModel($sformatf("%s_k%0d", tag, k), dir, k / p, k < total, k == total);
        end

        if (abort_at > 0) begin
            abort = 1'b1;
            #0;
            checkOutput({tag, "_ready_abort"}, 32'(cmd_if.cmd_ready), 32'd0);
            stepClk();
            edges = (abort_at - 1) / p;
            checkModel({tag, "_aborted"}, dir, edges, 1'b0, 1'b0);
            abort = 1'b0;
            #1;
            checkOutput({tag, "_ready_after_abort"}, 32'(cmd_if.cmd_ready), 32'd1);
            stepClk();
            checkModel({tag, "_held"}, dir, edges, 1'b0, 1'b0);
            commitModel(dir, edges);
        end else begin
            commitModel(dir, n);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        model_pos = 0;
        model_idx = 0;
        nrst      = 1'b0;
        abort     = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_period = '0;

        repeat (3) stepClk();
        nrst = 1'b1;
        stepClk();
        $display("[TB] reset state");
        checkModel("reset", 1, 0, 1'b0, 1'b0);
        checkOutput("reset_ready", 32'(cmd_if.cmd_ready), 32'd1);

        $display("[TB] forward, reverse and degenerate commands");
        applyStimulus("fwd4", 4, 3, 0);
        applyStimulus("rev5", -5, 2, 0);
        applyStimulus("zero", 0, 5, 0);
        applyStimulus("per0", 3, 0, 0);

        $display("[TB] abort cases");
        applyStimulus("abort", 10, 4, 12);
        abort = 1'b1;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = WIDTH'(7);
        cmd_if.cmd_period = DIV_W'(2);
        #0;
        checkOutput("idle_abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
        stepClk();
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        checkModel("idle_abort", 1, 0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-run");
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = WIDTH'(6);
        cmd_if.cmd_period = DIV_W'(3);
        stepClk();
        cmd_if.cmd_valid = 1'b0;
        repeat (4) stepClk();
        checkModel("pre_reset", 1, 1, 1'b1, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        model_pos = 0;
        model_idx = 0;
        checkModel("async_reset", 1, 0, 1'b0, 1'b0);
        #1;
        nrst = 1'b1;
        stepClk();

        $display("[TB] wrap and extreme commands");
        applyStimulus("to_m2", -2, 1, 0);
        checkOutput("wrap_start", 32'(position), 32'h003F_FFFE);
        applyStimulus("wrap", 3, 1, 0);
        checkOutput("wrap_end", 32'(position), 32'h0000_0001);
        applyStimulus("minneg", -(1 << 21), 2, 7);

        $display("[TB] random back-to-back commands");
        for (int i = 0; i < 12; i++) begin
            int n, s, p, a;
            n = $urandom_range(0, 6);
            s = ($urandom_range(0, 1) == 1) ? -n : n;
            p = $urandom_range(0, 4);
            a = 0;
            if (n > 0 && $urandom_range(0, 2) == 0)
                a = $urandom_range(1, n * ((p == 0) ? 1 : p));
            applyStimulus($sformatf("rnd%0d", i), s, p, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
